// File: rtl/madd_sequencer.sv
// Operand issue and result collection around the MADD multiply-add unit.
// Issue credit is granted only when FIFO space exists for every result still in flight.
module madd_sequencer #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [31:0]      in_c,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      ma,
    output logic [31:0]      mb,
    output logic [31:0]      mc,
    input  logic [31:0]      mz,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;

    logic             v1, v2;
    logic [TAG_W-1:0] t1, t2;

    logic [31:0]      z_mem   [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic             accept, pop, full, wr_en;
    logic [SUM_W-1:0] credit_sum;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept    = in_valid & in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count == CNT_W'(DEPTH));
    // A pop on the same edge frees the slot, so a write into a full FIFO is legal then.
    assign wr_en     = v2 & (~full | pop);

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        credit_sum = SUM_W'(count) + SUM_W'(v1) + SUM_W'(v2) - SUM_W'(pop);
        in_ready   = (credit_sum < SUM_W'(DEPTH));
    end

    assign busy    = v1 | v2 | out_valid;
    assign out_z   = z_mem[rd_ptr];
    assign out_tag = tag_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            t1 <= '0;
            ma <= '0;
            mb <= '0;
            mc <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                ma <= in_a;
                mb <= in_b;
                mc <= in_c;
                t1 <= in_tag;
            end
        end
    end

    // MADD registers Z on the same edge that moves t1 into t2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            t2 <= '0;
        end else begin
            v2 <= v1;
            t2 <= t1;
        end
    end

    // NOTE: FIFO storage has no reset; count and pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            z_mem[wr_ptr]   <= mz;
            tag_mem[wr_ptr] <= t2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (v2 && full && !pop) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_madd_sequencer.sv
// Directed bench for madd_sequencer with a behavioural MADD unit and an output monitor.
`timescale 1ns/1ps
module tb_madd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b, in_c;
    logic [3:0]  in_tag;
    logic [31:0] ma, mb, mc, mz;
    logic        out_valid, out_ready;
    logic [31:0] out_z;
    logic [3:0]  out_tag;
    logic        busy, err;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [31:0] got_z[$];
    logic [3:0]  got_t[$];
    int          got_c[$];
    logic [31:0] exp_z[$];
    logic [3:0]  exp_t[$];

    madd_sequencer #(.TAG_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag),
        .ma(ma), .mb(mb), .mc(mc), .mz(mz),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_tag(out_tag),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural MADD: Z registered one cycle after its operands, low 32 bits.
    always @(posedge clk) mz <= ma * mb + mc;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        #3;
        if (out_valid && out_ready) begin
            got_z.push_back(out_z);
            got_t.push_back(out_tag);
            got_c.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_queues();
        got_z.delete(); got_t.delete(); got_c.delete();
        exp_z.delete(); exp_t.delete();
    endtask

    // Called at a negedge; checks 3-cycle latency, result, tag and return to idle.
    task automatic single_op(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [3:0] t, input logic [31:0] ez);
        int lat;
        lat = 0;
        in_a = a; in_b = b; in_c = c; in_tag = t;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({name, "_latency"}, 32'(lat), 32'd3);
        check({name, "_z"}, out_z, ez);
        check({name, "_tag"}, 32'(out_tag), 32'(t));
        @(negedge clk);
        check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        clear_queues();
    endtask

    // Waits for the monitor to collect every expected result, then compares in order.
    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (got_z.size() >= exp_z.size()) break;
            @(negedge clk);
            #4;
        end
        check({name, "_count"}, 32'(got_z.size()), 32'(exp_z.size()));
        for (int i = 0; i < exp_z.size() && i < got_z.size(); i++) begin
            check($sformatf("%s_z[%0d]", name, i), got_z[i], exp_z[i]);
            check($sformatf("%s_tag[%0d]", name, i), 32'(got_t[i]), 32'(exp_t[i]));
        end
        clear_queues();
    endtask

    initial begin
        logic [31:0] b2b_z [8];
        int          acc;
        bit          ready_all;
        bit          stale;
        int          issued, guard;
        logic [31:0] ra, rb, rc;
        logic [3:0]  rt;

        b2b_z = '{32'd1, 32'd2, 32'd5, 32'd10, 32'd17, 32'd26, 32'd37, 32'd50};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_tag = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ma", ma, 32'd0);
        @(negedge clk);

        single_op("single", 32'd3, 32'd5, 32'd7, 4'd2, 32'd22);
        single_op("wrap_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'd9, 32'h0000_0001);
        single_op("wrap_16", 32'h0001_0000, 32'h0001_0000, 32'd5, 4'd4, 32'h0000_0005);

        // Back-to-back issue with the consumer always ready.
        ready_all = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_a = 32'(i); in_b = 32'(i); in_c = 32'd1; in_tag = 4'(i);
            in_valid = 1'b1;
            #1;
            if (!in_ready) ready_all = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_in_ready_held", 32'(ready_all), 32'd1);
        for (int k = 0; k < 20 && got_z.size() < 8; k++) begin
            @(negedge clk);
            #4;
        end
        check("b2b_count", 32'(got_z.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_z.size(); i++) begin
            check($sformatf("b2b_z[%0d]", i), got_z[i], b2b_z[i]);
            check($sformatf("b2b_tag[%0d]", i), 32'(got_t[i]), 32'(i));
            check($sformatf("b2b_cycle[%0d]", i), 32'(got_c[i] - got_c[0]), 32'(i));
        end
        clear_queues();
        @(negedge clk);

        // Backpressure: consumer stalled, operands offered every cycle.
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            in_a = 32'(acc + 2); in_b = 32'd3; in_c = 32'(acc); in_tag = 4'(acc);
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                exp_z.push_back(in_a * in_b + in_c);
                exp_t.push_back(in_tag);
                acc++;
            end
            @(negedge clk);
        end
        #1;
        check("bp_accepts", 32'(acc), 32'd4);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_head_valid", 32'(out_valid), 32'd1);
        check("bp_head_z", out_z, 32'd6);
        check("bp_head_tag", 32'(out_tag), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_ready_lookahead", 32'(in_ready), 32'd1);
        drain("bp");
        check("bp_err", 32'(err), 32'd0);
        @(negedge clk);

        // Random consumer stalls over many random operations.
        issued = 0;
        guard = 0;
        ra = $urandom; rb = $urandom; rc = $urandom; rt = 4'($urandom);
        while (issued < 1000 && guard < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_a = ra; in_b = rb; in_c = rc; in_tag = rt;
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                exp_z.push_back(ra * rb + rc);
                exp_t.push_back(rt);
                issued++;
                ra = $urandom; rb = $urandom; rc = $urandom; rt = 4'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        check("rand_issued", 32'(issued), 32'd1000);
        drain("rand");
        check("rand_err", 32'(err), 32'd0);
        @(negedge clk);

        // Reset with results in the FIFO, at MZ and at MA.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = 32'(i + 1); in_b = 32'd100; in_c = 32'd0; in_tag = 4'(i + 1);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        stale = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid || busy) stale = 1'b1;
        end
        check("mrst_no_stale", 32'(stale), 32'd0);
        clear_queues();
        single_op("post_rst", 32'd6, 32'd7, 32'd8, 4'd11, 32'd50);
        check("final_err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
